// File: rtl/recompute_scheduler_pkg.sv
// Shared types and helpers for the recompute scheduler: FSM state, request
// layout at default widths, and the one-hot tag check.
package recompute_sched_pkg;

   localparam int WORD_SIZE_D = 16;
   localparam int ROWS_D      = 4;
   localparam int COLS_D      = 4;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} sched_state_t;

   typedef struct packed {
      logic [WORD_SIZE_D-1:0] weight;
      logic [WORD_SIZE_D-1:0] left;
      logic [ROWS_D-1:0]      row;
      logic [COLS_D-1:0]      col;
   } recompute_req_t;

   // Tags narrower than 32 bits are zero-extended by the caller.
   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/recompute_scheduler_fifo.sv
// Request FIFO for the recompute scheduler. Power-of-two depth, so the
// pointers wrap by natural overflow; the extra count bit tells full from empty.
module recompute_req_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] rdata
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/recompute_scheduler.sv
// Queues recompute requests from faulty PEs and runs them one at a time
// through the shared recompute unit, handing results off with valid/ready.
module recompute_scheduler
   import recompute_sched_pkg::*;
#(
   parameter int WORD_SIZE = 16,
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [WORD_SIZE-1:0] req_weight,
   input  logic [WORD_SIZE-1:0] req_left,
   input  logic [ROWS-1:0]      req_row,
   input  logic [COLS-1:0]      req_col,
   output logic [WORD_SIZE-1:0] ru_weight,
   output logic [WORD_SIZE-1:0] ru_left,
   output logic [ROWS-1:0]      ru_row,
   output logic [COLS-1:0]      ru_col,
   input  logic [WORD_SIZE-1:0] ru_bottom,
   input  logic [ROWS-1:0]      ru_row_ret,
   input  logic [COLS-1:0]      ru_col_ret,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [WORD_SIZE-1:0] res_data,
   output logic [ROWS-1:0]      res_row,
   output logic [COLS-1:0]      res_col,
   output logic                 busy,
   output logic                 err_tag,
   output logic                 err_malformed,
   output logic [15:0]          done_count
);
   localparam int EW = 2*WORD_SIZE + ROWS + COLS;

   sched_state_t state_q, state_d;
   logic full, empty, push, pop, capture, handoff, req_ok;
   logic [EW-1:0]        head;
   logic [WORD_SIZE-1:0] h_weight, h_left;
   logic [ROWS-1:0]      h_row;
   logic [COLS-1:0]      h_col;

   assign req_ready = !full;
   assign req_ok    = is_onehot(32'(req_row)) && is_onehot(32'(req_col));
   // Malformed requests are acked but dropped so the array never stalls on them.
   assign push      = req_valid && req_ready && req_ok;
   assign busy      = (state_q != IDLE) || !empty;
   assign {h_weight, h_left, h_row, h_col} = head;

   recompute_req_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({req_weight, req_left, req_row, req_col}),
      .full  (full),
      .empty (empty),
      .rdata (head)
   );

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      capture = 1'b0;
      handoff = 1'b0;
      case (state_q)
         IDLE: if (!empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
         end
         ISSUE:   state_d = CAPTURE;
         CAPTURE: begin
            capture = 1'b1;
            state_d = DONE;
         end
         DONE: if (res_ready) begin
            handoff = 1'b1;
            pop     = !empty;
            state_d = empty ? IDLE : ISSUE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         ru_weight     <= '0;
         ru_left       <= '0;
         ru_row        <= '0;
         ru_col        <= '0;
         res_valid     <= 1'b0;
         res_data      <= '0;
         res_row       <= '0;
         res_col       <= '0;
         err_tag       <= 1'b0;
         err_malformed <= 1'b0;
         done_count    <= '0;
      end else begin
         state_q <= state_d;
         if (req_valid && req_ready && !req_ok) err_malformed <= 1'b1;
         if (pop) begin
            ru_weight <= h_weight;
            ru_left   <= h_left;
            ru_row    <= h_row;
            ru_col    <= h_col;
         end
         // Result carries the issued tags; a bad echo only raises the flag.
         if (capture) begin
            res_data  <= ru_bottom;
            res_row   <= ru_row;
            res_col   <= ru_col;
            res_valid <= 1'b1;
            if ((ru_row_ret != ru_row) || (ru_col_ret != ru_col)) err_tag <= 1'b1;
         end
         if (handoff) begin
            res_valid  <= 1'b0;
            done_count <= done_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_recompute_scheduler.sv
// Directed bench for recompute_scheduler with a behavioural recompute unit
// (registered product and tag echo, with an optional row-tag fault).
module tb_recompute_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready;
   logic [15:0] req_weight = '0, req_left = '0;
   logic [3:0]  req_row = '0, req_col = '0;
   logic [15:0] ru_weight, ru_left, ru_bottom;
   logic [3:0]  ru_row, ru_col, ru_row_ret, ru_col_ret;
   logic        res_valid, res_ready = 1'b0;
   logic [15:0] res_data;
   logic [3:0]  res_row, res_col;
   logic        busy, err_tag, err_malformed;
   logic [15:0] done_count;

   logic [15:0] u_bottom = '0;
   logic [3:0]  u_row = '0, u_col = '0;
   logic        fault = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   recompute_scheduler #(.WORD_SIZE(16), .ROWS(4), .COLS(4), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_weight(req_weight), .req_left(req_left), .req_row(req_row), .req_col(req_col),
      .ru_weight(ru_weight), .ru_left(ru_left), .ru_row(ru_row), .ru_col(ru_col),
      .ru_bottom(ru_bottom), .ru_row_ret(ru_row_ret), .ru_col_ret(ru_col_ret),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_row(res_row), .res_col(res_col),
      .busy(busy), .err_tag(err_tag), .err_malformed(err_malformed),
      .done_count(done_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      u_bottom <= 16'(ru_weight * ru_left);
      u_row    <= ru_row;
      u_col    <= ru_col;
   end
   assign ru_bottom  = u_bottom;
   assign ru_row_ret = fault ? 4'b0100 : u_row;
   assign ru_col_ret = u_col;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_res();
      int n = 0;
      while (!res_valid && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_checks++;
      if ({req_ready, res_valid, busy, err_tag, err_malformed} !== 5'b10000) begin
         $display("FAIL reset_flags got %b want 10000", {req_ready, res_valid, busy, err_tag, err_malformed});
         n_fail++;
      end
      n_checks++;
      if ({done_count, res_data, res_row, res_col} !== 40'd0) begin
         $display("FAIL reset_res got cnt=%0d data=%0d row=%b col=%b want 0", done_count, res_data, res_row, res_col);
         n_fail++;
      end
      n_checks++;
      if ({ru_weight, ru_left, ru_row, ru_col} !== 40'd0) begin
         $display("FAIL reset_ru got w=%0d l=%0d row=%b col=%b want 0", ru_weight, ru_left, ru_row, ru_col);
         n_fail++;
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      res_ready  = 1'b1;
      req_valid  = 1'b1;
      req_weight = 16'd3;
      req_left   = 16'd5;
      req_row    = 4'b0001;
      req_col    = 4'b0010;
      tick();                                   // E0 accept
      req_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         $display("FAIL single_busy got %b want 1", busy);
         n_fail++;
      end
      tick();                                   // E1 issue
      n_checks++;
      if ({ru_weight, ru_left, ru_row, ru_col} !== {16'd3, 16'd5, 4'b0001, 4'b0010}) begin
         $display("FAIL single_issue got w=%0d l=%0d row=%b col=%b want 3 5 0001 0010", ru_weight, ru_left, ru_row, ru_col);
         n_fail++;
      end
      tick();                                   // E2 unit latch
      n_checks++;
      if (res_valid !== 1'b0) begin
         $display("FAIL single_early_valid got %b want 0", res_valid);
         n_fail++;
      end
      tick();                                   // E3 capture
      n_checks++;
      if ({res_valid, res_data, res_row, res_col} !== {1'b1, 16'd15, 4'b0001, 4'b0010}) begin
         $display("FAIL single_result got v=%b d=%0d row=%b col=%b want 1 15 0001 0010", res_valid, res_data, res_row, res_col);
         n_fail++;
      end
      tick();                                   // handoff
      n_checks++;
      if ({res_valid, busy, done_count} !== {1'b0, 1'b0, 16'd1}) begin
         $display("FAIL single_handoff got v=%b busy=%b cnt=%0d want 0 0 1", res_valid, busy, done_count);
         n_fail++;
      end
   endtask

   task automatic test_fill();
      logic [15:0] wts [5] = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd10};
      logic [15:0] lfs [5] = '{16'd3, 16'd5, 16'd7, 16'd9, 16'd11};
      logic [15:0] prd [5] = '{16'd6, 16'd20, 16'd42, 16'd72, 16'd110};
      logic [3:0]  rws [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0]  cls [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         req_valid  = 1'b1;
         req_weight = wts[i];
         req_left   = lfs[i];
         req_row    = rws[i];
         req_col    = cls[i];
         n_checks++;
         if (req_ready !== 1'b1) begin
            $display("FAIL fill_ready_%0d got %b want 1", i, req_ready);
            n_fail++;
         end
         tick();
      end
      req_valid = 1'b0;
      n_checks++;
      if (req_ready !== 1'b0) begin
         $display("FAIL fill_full got req_ready=%b want 0", req_ready);
         n_fail++;
      end
      tick();
      tick();
      n_checks++;
      if ({res_valid, res_data} !== {1'b1, 16'd6}) begin
         $display("FAIL fill_held got v=%b d=%0d want 1 6", res_valid, res_data);
         n_fail++;
      end
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_res();
         n_checks++;
         if ({res_valid, res_data, res_row, res_col} !== {1'b1, prd[i], rws[i], cls[i]}) begin
            $display("FAIL fill_result_%0d got v=%b d=%0d row=%b col=%b want 1 %0d %b %b",
                     i, res_valid, res_data, res_row, res_col, prd[i], rws[i], cls[i]);
            n_fail++;
         end
         tick();
      end
      n_checks++;
      if ({done_count, busy, err_tag} !== {16'd6, 1'b0, 1'b0}) begin
         $display("FAIL fill_done got cnt=%0d busy=%b err_tag=%b want 6 0 0", done_count, busy, err_tag);
         n_fail++;
      end
   endtask

   task automatic test_stall();
      bit stable = 1'b1;
      res_ready  = 1'b0;
      req_valid  = 1'b1;
      req_weight = 16'd5;
      req_left   = 16'd6;
      req_row    = 4'b0010;
      req_col    = 4'b0100;
      tick();
      req_weight = 16'd9;
      req_left   = 16'd11;
      req_row    = 4'b1000;
      req_col    = 4'b0001;
      tick();
      req_valid = 1'b0;
      wait_res();
      n_checks++;
      if ({res_valid, res_data} !== {1'b1, 16'd30}) begin
         $display("FAIL stall_first got v=%b d=%0d want 1 30", res_valid, res_data);
         n_fail++;
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!(res_valid && res_data == 16'd30 && res_row == 4'b0010 && res_col == 4'b0100 && ru_weight == 16'd5))
            stable = 1'b0;
      end
      n_checks++;
      if (stable !== 1'b1) begin
         $display("FAIL stall_stable got changed outputs (v=%b d=%0d ru_w=%0d) want held", res_valid, res_data, ru_weight);
         n_fail++;
      end
      res_ready = 1'b1;
      tick();
      n_checks++;
      if ({res_valid, ru_weight} !== {1'b0, 16'd9}) begin
         $display("FAIL stall_reissue got v=%b ru_w=%0d want 0 9", res_valid, ru_weight);
         n_fail++;
      end
      tick();
      n_checks++;
      if (res_valid !== 1'b0) begin
         $display("FAIL stall_gap got v=%b want 0", res_valid);
         n_fail++;
      end
      tick();
      n_checks++;
      if ({res_valid, res_data, res_row, res_col} !== {1'b1, 16'd99, 4'b1000, 4'b0001}) begin
         $display("FAIL stall_second got v=%b d=%0d row=%b col=%b want 1 99 1000 0001", res_valid, res_data, res_row, res_col);
         n_fail++;
      end
      tick();
      n_checks++;
      if ({done_count, busy} !== {16'd8, 1'b0}) begin
         $display("FAIL stall_done got cnt=%0d busy=%b want 8 0", done_count, busy);
         n_fail++;
      end
   endtask

   task automatic test_malformed();
      res_ready  = 1'b1;
      req_valid  = 1'b1;
      req_weight = 16'd1;
      req_left   = 16'd1;
      req_row    = 4'b0011;
      req_col    = 4'b0001;
      n_checks++;
      if (req_ready !== 1'b1) begin
         $display("FAIL malformed_ack got %b want 1", req_ready);
         n_fail++;
      end
      tick();
      req_valid = 1'b0;
      n_checks++;
      if ({err_malformed, busy} !== 2'b10) begin
         $display("FAIL malformed_flag got err=%b busy=%b want 1 0", err_malformed, busy);
         n_fail++;
      end
      req_valid  = 1'b1;
      req_weight = 16'd7;
      req_left   = 16'd9;
      req_row    = 4'b0100;
      req_col    = 4'b1000;
      tick();
      req_valid = 1'b0;
      wait_res();
      n_checks++;
      if ({res_valid, res_data, res_row, res_col} !== {1'b1, 16'd63, 4'b0100, 4'b1000}) begin
         $display("FAIL malformed_next got v=%b d=%0d row=%b col=%b want 1 63 0100 1000", res_valid, res_data, res_row, res_col);
         n_fail++;
      end
      tick();
      n_checks++;
      if ({done_count, err_malformed, err_tag} !== {16'd9, 1'b1, 1'b0}) begin
         $display("FAIL malformed_after got cnt=%0d err_m=%b err_t=%b want 9 1 0", done_count, err_malformed, err_tag);
         n_fail++;
      end
   endtask

   task automatic test_tag_fault();
      fault      = 1'b1;
      res_ready  = 1'b1;
      req_valid  = 1'b1;
      req_weight = 16'd12;
      req_left   = 16'd12;
      req_row    = 4'b0001;
      req_col    = 4'b0001;
      tick();
      req_valid = 1'b0;
      wait_res();
      n_checks++;
      if ({res_valid, res_data, res_row, err_tag} !== {1'b1, 16'd144, 4'b0001, 1'b1}) begin
         $display("FAIL tag_result got v=%b d=%0d row=%b err_tag=%b want 1 144 0001 1", res_valid, res_data, res_row, err_tag);
         n_fail++;
      end
      tick();
      fault = 1'b0;
      tick();
      n_checks++;
      if ({err_tag, done_count} !== {1'b1, 16'd10}) begin
         $display("FAIL tag_sticky got err_tag=%b cnt=%0d want 1 10", err_tag, done_count);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid();
      bit quiet = 1'b1;
      res_ready = 1'b0;
      req_valid = 1'b1;
      req_row   = 4'b0010;
      req_col   = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         req_weight = 16'(i + 20);
         req_left   = 16'd3;
         tick();
      end
      req_valid = 1'b0;
      // now in CAPTURE with two entries queued
      rst = 1'b1;
      #1;
      n_checks++;
      if ({res_valid, busy, req_ready, err_tag, err_malformed} !== 5'b00100) begin
         $display("FAIL rstmid_flags got v=%b busy=%b rdy=%b et=%b em=%b want 0 0 1 0 0",
                  res_valid, busy, req_ready, err_tag, err_malformed);
         n_fail++;
      end
      n_checks++;
      if ({done_count, ru_weight} !== 32'd0) begin
         $display("FAIL rstmid_regs got cnt=%0d ru_w=%0d want 0 0", done_count, ru_weight);
         n_fail++;
      end
      tick();
      rst       = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (res_valid || busy) quiet = 1'b0;
      end
      n_checks++;
      if (quiet !== 1'b1) begin
         $display("FAIL rstmid_stale got activity after reset (v=%b busy=%b) want none", res_valid, busy);
         n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_stall();
      test_malformed();
      test_tag_fault();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/recompute_scheduler.md
# recompute_scheduler

Sequences recompute requests from faulty PEs in the BIST/BISR systolic array onto the single shared `recompute_unit`. Buffers requests in a small FIFO and issues one at a time by driving the unit's Weight/LeftIn/faulty-tag inputs. Collects the registered product and checks the returned row/column tags against the issued ones. Delivers each result with a valid/ready handshake to the array's output-patching logic.

## Interface
- `WORD_SIZE`, 16, operand and result width (same as `recompute_unit`)
- `ROWS`, 4, array rows; width of the one-hot row tag
- `COLS`, 4, array columns; width of the one-hot column tag
- `DEPTH`, 4, request FIFO entries (power of 2, ≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted this cycle when high with `req_valid`
- `req_weight`  in  WORD_SIZE  weight of faulty PE
- `req_left`  in  WORD_SIZE  left operand of faulty PE
- `req_row`  in  ROWS  one-hot faulty row
- `req_col`  in  COLS  one-hot faulty column
- `ru_weight`  out  WORD_SIZE  to unit `Weight`
- `ru_left`  out  WORD_SIZE  to unit `LeftIn`
- `ru_row`  out  ROWS  to unit `faultyRowIn`
- `ru_col`  out  COLS  to unit `faultyColIn`
- `ru_bottom`  in  WORD_SIZE  from unit `BottomOut`
- `ru_row_ret`  in  ROWS  from unit `faultyRowOut`
- `ru_col_ret`  in  COLS  from unit `faultyColOut`
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer takes result
- `res_data`  out  WORD_SIZE  recomputed product
- `res_row`  out  ROWS  row tag of result
- `res_col`  out  COLS  column tag of result
- `busy`  out  1  FSM not IDLE or FIFO non-empty
- `err_tag`  out  1  sticky: returned tag ≠ issued tag
- `err_malformed`  out  1  sticky: non-one-hot request seen
- `done_count`  out  16  results handed off, wraps at 2^16

## Operation
- Push on `req_valid && req_ready`. `req_ready = !full`.
- A request whose `req_row` or `req_col` is not exactly one-hot is still acknowledged, but it is not pushed and it sets `err_malformed`.
- The FIFO may push and pop in the same cycle. Full count stays full, and `req_ready` is driven from the registered count.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
  - IDLE: if the FIFO is non-empty, pop the head, register it into `ru_*`, and go to ISSUE.
  - ISSUE: the unit latches `Weight*LeftIn` (truncated to WORD_SIZE by the unit) on this edge. Go to CAPTURE.
  - CAPTURE: register `ru_bottom` into `res_data`, register the issued `ru_row`/`ru_col` into `res_row`/`res_col`, and set `res_valid`. If `ru_row_ret != ru_row` or `ru_col_ret != ru_col`, set `err_tag`; the result is still delivered. Go to DONE.
  - DONE: hold `res_*` stable while `!res_ready`. On `res_ready`:
    - clear `res_valid` and increment `done_count`;
    - if the FIFO is non-empty, pop and load `ru_*` in the same edge and go to ISSUE;
    - otherwise go to IDLE.
- `ru_*` registers hold their last value between issues. The unit recomputes continuously, which is harmless.
- Error flags clear only on `rst`.

## Timing
- Reset values:
  - `req_ready`=1, `res_valid`=0, `busy`=0, flags=0, `done_count`=0
  - `res_data`/`res_row`/`res_col`/`ru_*` = 0
  - FSM = IDLE, FIFO empty
- Latency, with the FSM in IDLE:
  - request accepted at edge E0;
  - popped and issued at E1;
  - unit product latched at E2;
  - `res_valid` high after E3 (3 cycles).
- Back-to-back throughput is one result per 3 cycles when `res_ready` is held high.
- A request pushed into an empty FIFO cannot be popped in the same edge.
- `res_ready` high while `res_valid` is low is ignored.
- Reset asserted mid-operation: the FIFO, the FSM and all outputs go to their reset values immediately. In-flight results are lost.
- `done_count` wraps from 0xFFFF to 0.

## Structure
- Package `recompute_sched_pkg` contains:
  - the FSM state typedef `sched_state_t` (IDLE, ISSUE, CAPTURE, DONE);
  - the request struct `recompute_req_t` (weight, left, row, col), parameterized by the package's default widths;
  - the `is_onehot` function.
- Sub-module `recompute_req_fifo`:
  - parameters DEPTH and entry width;
  - ports: push/pop, full/empty, head data;
  - the pointer-wrap logic lives there.
- The top level instantiates the FIFO and the FSM. It does not instantiate `recompute_unit`; integration wires the two together.

## Test plan
- Single request: weight=3, left=5, row=0001, col=0010 with `res_ready`=1 → `res_valid` 3 cycles after accept, `res_data`=15, tags echoed, `done_count`=1.
- Fill: 5 back-to-back requests with DEPTH=4 and `res_ready`=0 → `req_ready` drops once 4 entries are queued (one already issued). Release `res_ready` → all 5 results in order, `done_count`=5.
- Stall: hold `res_ready`=0 for 10 cycles → `res_*` stable, no further issue. Then release → the next result follows 2 cycles later via the DONE→ISSUE path.
- Malformed: row=0011 → accepted, nothing queued, `err_malformed`=1. A following valid request still completes normally.
- Tag fault: force `ru_row_ret`=0100 while issued row=0001 → `err_tag`=1 (sticky), result still delivered.
- Reset mid-operation: assert `rst` in CAPTURE with 2 entries queued → `res_valid`=0, `busy`=0, `req_ready`=1 immediately. No stale results appear after release.
